transmitter_fsm: RTL and testbench
==================================

Name: transmitter_fsm

Overview:
UART serial transmitter; the transmit-side counterpart of the team's 16x-oversampling UART receiver.
- Accepts bytes over a valid/ready handshake into a one-byte holding register.
- Serialises each byte as: start bit, 8 data bits LSB first, parity bit, stop bit(s).
- Every bit is held for OVERSAMPLE ticks of the baud clock.
- Sits between the host/byte source and the physical TX line.

Parameters:
OVERSAMPLE, 16, baud clock cycles per serial bit (must be >=2).
PARITY_ODD, 0, 0 = even parity, 1 = odd parity.
STOP_BITS, 1, number of stop bits (1 or 2).

Ports:
baudOut  input  1  clock; oversampled baud tick clock (OVERSAMPLE x bit rate); all logic on posedge.
rst  input  1  synchronous active-low reset.
dataIn  input  8  byte to transmit; sampled only on an accepted handshake.
dataValid  input  1  source has a byte on dataIn.
dataReady  output  1  holding register empty; a byte is accepted on an edge where dataValid && dataReady.
serialOutput  output  1  TX line; idle high.
busy  output  1  high while a frame is on the line (start through last stop cycle).
frameDone  output  1  one-cycle pulse after each completed frame.

Behaviour:
- Reset is sampled on posedge baudOut while rst=0. It forces:
  - serialOutput=1, busy=0, dataReady=1, frameDone=0.
  - state IDLE; tick counter, bit index and stop counter all 0.
  - holding register emptied.
- Reset mid-frame aborts the frame: line high from that edge; no frameDone pulse.
- dataValid is ignored while rst=0.
- Holding register:
  - dataReady = !hold_full.
  - An accepted handshake latches dataIn and sets hold_full on the same edge.
  - Later changes on dataIn have no effect on the latched byte.
- States: IDLE, START, DATA, PARITY, STOP. A tick counter runs 0..OVERSAMPLE-1 within every bit.
- IDLE:
  - serialOutput=1, busy=0.
  - If hold_full=1 at an edge: load shift register from the holding register, clear hold_full, compute parity, reset the tick counter, go to START.
  - serialOutput=0 and busy=1 from that edge.
  - Latency: byte accepted at edge E0 -> start bit begins at edge E0+1.
- START: serialOutput=0 for OVERSAMPLE cycles, then go to DATA with bit index 0.
- DATA:
  - serialOutput=shift[0] for OVERSAMPLE cycles.
  - Shift right at each bit end; bit index 0..7.
  - After bit 7 completes, go to PARITY.
- PARITY:
  - serialOutput = (XOR of the 8 data bits) XOR PARITY_ODD, for OVERSAMPLE cycles.
  - Then go to STOP.
- STOP: serialOutput=1 for STOP_BITS*OVERSAMPLE cycles.
- Last STOP tick edge:
  - frameDone=1 for exactly the following cycle.
  - If hold_full (registered value) =1: go directly to START, loading as in IDLE. No idle gap; busy stays 1.
  - Else: go to IDLE, busy=0.
  - A byte accepted on that same edge is not seen: the block spends one IDLE cycle, then START.
- Frame length: (10+STOP_BITS)*OVERSAMPLE cycles exactly; 176 cycles at defaults.
- A handshake is accepted in any state, including mid-frame, whenever hold_full=0.
- dataReady is low from the accepting edge until the byte is transferred to the shift register.
- All outputs are registered; serialOutput is glitch-free.

Test Plan:
- Reset: hold rst=0 for 3 cycles with dataValid=1 -> serialOutput=1, busy=0, dataReady=1, frameDone=0, no frame starts.
- Single byte 0xA5, even parity, defaults:
  - Line levels, 16 cycles each: 0 | 1,0,1,0,0,1,0,1 | parity 0 | stop 1.
  - Start bit begins one cycle after acceptance; busy high for exactly 176 cycles.
  - One frameDone pulse.
- Odd parity (PARITY_ODD=1), byte 0x00 -> data bits all 0, parity bit 1; byte 0xFF -> parity bit 1.
- Back-to-back bytes:
  - 0x55 accepted, then 0x0F accepted at cycle 20 of the frame.
  - dataReady=0 from cycle 20 until the second load.
  - Second start bit follows the first stop bit with zero gap; busy continuous for 352 cycles.
  - Two frameDone pulses, 176 cycles apart.
- Reset mid-frame: during DATA bit 3 of 0x3C, assert rst=0 for 1 cycle -> serialOutput=1 from that edge, busy=0, dataReady=1, no frameDone; the next byte sent afterwards is a clean full frame.
- STOP_BITS=2, byte 0x81 -> stop high for 32 cycles; frame 192 cycles; loopback into the team receiver yields dataParityOut=9'h081.

Source files
------------

// File: rtl/transmitter_fsm.sv
// ============================================================================
// transmitter_fsm
// ----------------------------------------------------------------------------
// UART serial transmitter. A byte enters through a valid/ready handshake into a
// one-byte holding register. It then goes out on the TX line as a start bit,
// 8 data bits LSB first, a parity bit and STOP_BITS stop bits. Each bit lasts
// OVERSAMPLE cycles of the baud tick clock. When a byte is already waiting at
// the end of a frame, the next frame starts with no idle gap.
//
// Parameters
//   OVERSAMPLE   baud clock cycles per serial bit (>= 2)
//   PARITY_ODD   0 = even parity, 1 = odd parity
//   STOP_BITS    number of stop bits (1 or 2)
//
// Ports
//   baudOut       in   clock, OVERSAMPLE x bit rate, posedge active
//   rst           in   synchronous active-low reset
//   dataIn[7:0]   in   byte to transmit, latched on an accepted handshake
//   dataValid     in   source presents a byte on dataIn
//   dataReady     out  holding register empty (handshake accepted when both high)
//   serialOutput  out  TX line, idle high
//   busy          out  high while a frame is on the line
//   frameDone     out  one-cycle pulse after each completed frame
// ============================================================================
module transmitter_fsm #(
    parameter int unsigned OVERSAMPLE = 16,
    parameter bit          PARITY_ODD = 1'b0,
    parameter int unsigned STOP_BITS  = 1
) (
    input  logic       baudOut,
    input  logic       rst,
    input  logic [7:0] dataIn,
    input  logic       dataValid,
    output logic       dataReady,
    output logic       serialOutput,
    output logic       busy,
    output logic       frameDone
);

    localparam int unsigned TICK_W = (OVERSAMPLE > 1) ? $clog2(OVERSAMPLE) : 1;
    localparam int unsigned BIT_W  = 3;
    localparam int unsigned STOP_W = 1;

    localparam logic [TICK_W-1:0] TICK_LAST = TICK_W'(OVERSAMPLE - 1);
    localparam logic [BIT_W-1:0]  BIT_LAST  = BIT_W'(7);
    localparam logic [STOP_W-1:0] STOP_LAST = STOP_W'(STOP_BITS - 1);

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_START  = 3'd1,
        S_DATA   = 3'd2,
        S_PARITY = 3'd3,
        S_STOP   = 3'd4
    } state_t;

    // ------------------------------------------------------------------------
    // Registers
    // ------------------------------------------------------------------------
    state_t              r_state;
    logic [TICK_W-1:0]   r_tick;
    logic [BIT_W-1:0]    r_bit;
    logic [STOP_W-1:0]   r_stop;
    logic [7:0]          r_shift;
    logic                r_parity;
    logic [7:0]          r_hold;
    logic                r_hold_full;
    logic                r_ready;
    logic                r_tx;
    logic                r_busy;
    logic                r_done;

    // ------------------------------------------------------------------------
    // Next-state / next-output wires
    // ------------------------------------------------------------------------
    state_t              w_state_nxt;
    logic [TICK_W-1:0]   w_tick_nxt;
    logic [BIT_W-1:0]    w_bit_nxt;
    logic [STOP_W-1:0]   w_stop_nxt;
    logic [7:0]          w_shift_nxt;
    logic                w_parity_nxt;
    logic                w_load;
    logic                w_frame_end;
    logic                w_tick_last;
    logic                w_accept;
    logic                w_tx_nxt;
    logic                w_busy_nxt;
    logic                w_done_nxt;

    assign w_tick_last = (r_tick == TICK_LAST);

    // Handshake uses the registered holding flag, so a byte accepted on the
    // last stop edge is only seen by the FSM on the following edge.
    assign w_accept    = dataValid & ~r_hold_full;

    // ------------------------------------------------------------------------
    // State register and datapath registers
    // ------------------------------------------------------------------------
    always_ff @(posedge baudOut) begin
        if (!rst) begin
            r_state     <= S_IDLE;
            r_tick      <= '0;
            r_bit       <= '0;
            r_stop      <= '0;
            r_shift     <= '0;
            r_parity    <= 1'b0;
            r_hold      <= '0;
            r_hold_full <= 1'b0;
            r_ready     <= 1'b1;
            r_tx        <= 1'b1;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
        end else begin
            r_state  <= w_state_nxt;
            r_tick   <= w_tick_nxt;
            r_bit    <= w_bit_nxt;
            r_stop   <= w_stop_nxt;
            r_shift  <= w_shift_nxt;
            r_parity <= w_parity_nxt;
            r_tx     <= w_tx_nxt;
            r_busy   <= w_busy_nxt;
            r_done   <= w_done_nxt;

            // Load and accept are mutually exclusive: load needs a full
            // holding register, accept needs an empty one.
            if (w_load) begin
                r_hold_full <= 1'b0;
                r_ready     <= 1'b1;
            end else if (w_accept) begin
                r_hold      <= dataIn;
                r_hold_full <= 1'b1;
                r_ready     <= 1'b0;
            end
        end
    end

    // ------------------------------------------------------------------------
    // Next-state logic: bit sequencing and tick counting
    // ------------------------------------------------------------------------
    always_comb begin
        w_state_nxt  = r_state;
        w_tick_nxt   = r_tick + TICK_W'(1);
        w_bit_nxt    = r_bit;
        w_stop_nxt   = r_stop;
        w_shift_nxt  = r_shift;
        w_parity_nxt = r_parity;
        w_load       = 1'b0;
        w_frame_end  = 1'b0;

        case (r_state)
            S_IDLE: begin
                w_tick_nxt = '0;
                w_load     = r_hold_full;
            end

            S_START: begin
                if (w_tick_last) begin
                    w_state_nxt = S_DATA;
                    w_tick_nxt  = '0;
                    w_bit_nxt   = '0;
                end
            end

            S_DATA: begin
                if (w_tick_last) begin
                    w_tick_nxt  = '0;
                    w_shift_nxt = {1'b0, r_shift[7:1]};
                    if (r_bit == BIT_LAST) begin
                        w_state_nxt = S_PARITY;
                    end else begin
                        w_bit_nxt = r_bit + BIT_W'(1);
                    end
                end
            end

            S_PARITY: begin
                if (w_tick_last) begin
                    w_state_nxt = S_STOP;
                    w_tick_nxt  = '0;
                    w_stop_nxt  = '0;
                end
            end

            S_STOP: begin
                if (w_tick_last) begin
                    w_tick_nxt = '0;
                    if (r_stop == STOP_LAST) begin
                        w_frame_end = 1'b1;
                        w_state_nxt = S_IDLE;
                        w_load      = r_hold_full;
                    end else begin
                        w_stop_nxt = r_stop + STOP_W'(1);
                    end
                end
            end

            default: begin
                w_state_nxt = S_IDLE;
                w_tick_nxt  = '0;
            end
        endcase

        // Transfer holding register into the shifter and start a new frame.
        if (w_load) begin
            w_state_nxt  = S_START;
            w_tick_nxt   = '0;
            w_bit_nxt    = '0;
            w_stop_nxt   = '0;
            w_shift_nxt  = r_hold;
            w_parity_nxt = (^r_hold) ^ PARITY_ODD;
        end
    end

    // ------------------------------------------------------------------------
    // Output logic: line level for the upcoming cycle, registered next edge
    // ------------------------------------------------------------------------
    always_comb begin
        w_tx_nxt   = 1'b1;
        w_busy_nxt = (w_state_nxt != S_IDLE);
        w_done_nxt = w_frame_end;

        case (w_state_nxt)
            S_START:  w_tx_nxt = 1'b0;
            S_DATA:   w_tx_nxt = w_shift_nxt[0];
            S_PARITY: w_tx_nxt = w_parity_nxt;
            default:  w_tx_nxt = 1'b1;
        endcase
    end

    assign dataReady    = r_ready;
    assign serialOutput = r_tx;
    assign busy         = r_busy;
    assign frameDone    = r_done;

endmodule

// File: tb/tb_transmitter_fsm.sv
// ============================================================================
// tb_transmitter_fsm
// ----------------------------------------------------------------------------
// Two transmitters run side by side. One uses the defaults (16x, even parity,
// one stop bit). The other uses 4x, odd parity and two stop bits. A frame-level
// reference model predicts every output each cycle. When the model loads a
// byte, it builds the frame as a list of bit levels, and the expected line
// level is the entry under the current cycle position.
// ============================================================================
module tb_transmitter_fsm;

    localparam int NI = 2;

    typedef struct {
        logic [7:0] b;
        int         dly;
    } item_t;

    logic       clk = 1'b0;
    logic       rst;
    logic [7:0] data_in    [NI];
    logic       data_valid [NI];
    logic       data_ready [NI];
    logic       serial_out [NI];
    logic       busy       [NI];
    logic       frame_done [NI];

    always #5 clk = ~clk;

    transmitter_fsm #(
        .OVERSAMPLE (16),
        .PARITY_ODD (1'b0),
        .STOP_BITS  (1)
    ) u_dut_def (
        .baudOut      (clk),
        .rst          (rst),
        .dataIn       (data_in[0]),
        .dataValid    (data_valid[0]),
        .dataReady    (data_ready[0]),
        .serialOutput (serial_out[0]),
        .busy         (busy[0]),
        .frameDone    (frame_done[0])
    );

    transmitter_fsm #(
        .OVERSAMPLE (4),
        .PARITY_ODD (1'b1),
        .STOP_BITS  (2)
    ) u_dut_alt (
        .baudOut      (clk),
        .rst          (rst),
        .dataIn       (data_in[1]),
        .dataValid    (data_valid[1]),
        .dataReady    (data_ready[1]),
        .serialOutput (serial_out[1]),
        .busy         (busy[1]),
        .frameDone    (frame_done[1])
    );

    function automatic int os_of(input int i);
        return (i == 0) ? 16 : 4;
    endfunction

    function automatic int nstop_of(input int i);
        return (i == 0) ? 1 : 2;
    endfunction

    function automatic logic podd_of(input int i);
        return (i == 0) ? 1'b0 : 1'b1;
    endfunction

    // ------------------------------------------------------------------------
    // Counters and checker
    // ------------------------------------------------------------------------
    int n_vec = 0;
    int n_err = 0;

    task automatic chk(input string tag, input logic got, input logic exp);
        n_vec++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s @%0t: got %b expected %b", tag, $time, got, exp);
        end
    endtask

    // ------------------------------------------------------------------------
    // Per-instance send queues
    // ------------------------------------------------------------------------
    item_t q0[$];
    item_t q1[$];

    function automatic int q_size(input int i);
        return (i == 0) ? q0.size() : q1.size();
    endfunction

    function automatic item_t q_head(input int i);
        return (i == 0) ? q0[0] : q1[0];
    endfunction

    function automatic void q_dec(input int i);
        if (i == 0) q0[0].dly = q0[0].dly - 1;
        else        q1[0].dly = q1[0].dly - 1;
    endfunction

    function automatic void q_pop(input int i);
        if (i == 0) void'(q0.pop_front());
        else        void'(q1.pop_front());
    endfunction

    function automatic void push(input int i, input logic [7:0] b, input int dly);
        item_t it;
        it.b   = b;
        it.dly = dly;
        if (i == 0) q0.push_back(it);
        else        q1.push_back(it);
    endfunction

    // ------------------------------------------------------------------------
    // Reference model: frame as list of bit levels plus a cycle position
    // ------------------------------------------------------------------------
    int          m_pos       [NI];
    int          m_len       [NI];
    logic [11:0] m_bits      [NI];
    logic        m_hold_full [NI];
    logic [7:0]  m_hold      [NI];
    logic        m_done      [NI];

    function automatic void model_step(input int i);
        logic full_old;
        logic accept;
        logic par;
        if (!rst) begin
            m_pos[i]       = 0;
            m_len[i]       = 0;
            m_bits[i]      = '1;
            m_hold_full[i] = 1'b0;
            m_hold[i]      = '0;
            m_done[i]      = 1'b0;
            return;
        end
        full_old  = m_hold_full[i];
        accept    = data_valid[i] && !full_old;
        m_done[i] = 1'b0;
        if (m_len[i] != 0) begin
            m_pos[i]++;
            if (m_pos[i] == m_len[i]) begin
                m_len[i]  = 0;
                m_done[i] = 1'b1;
            end
        end
        if (m_len[i] == 0 && full_old) begin
            par            = (^m_hold[i]) ^ podd_of(i);
            m_bits[i]      = {2'b11, par, m_hold[i], 1'b0};
            m_pos[i]       = 0;
            m_len[i]       = (10 + nstop_of(i)) * os_of(i);
            m_hold_full[i] = 1'b0;
        end
        if (accept) begin
            m_hold[i]      = data_in[i];
            m_hold_full[i] = 1'b1;
            q_pop(i);
        end
    endfunction

    function automatic logic exp_tx(input int i);
        if (m_len[i] == 0) return 1'b1;
        return m_bits[i][m_pos[i] / os_of(i)];
    endfunction

    // ------------------------------------------------------------------------
    // Stimulus: drive for the upcoming edge, then advance the model
    // ------------------------------------------------------------------------
    int rst_cnt = 0;

    task automatic drive_and_step();
        item_t h;
        if (rst_cnt > 0) begin
            rst = 1'b0;
            rst_cnt--;
        end else begin
            rst = 1'b1;
        end
        for (int i = 0; i < NI; i++) begin
            data_valid[i] = 1'b0;
            data_in[i]    = 8'($urandom);
            if (q_size(i) > 0) begin
                h = q_head(i);
                if (h.dly > 0) begin
                    q_dec(i);
                end else begin
                    data_valid[i] = 1'b1;
                    data_in[i]    = h.b;
                end
            end
        end
        for (int i = 0; i < NI; i++) model_step(i);
    endtask

    task automatic cycle();
        @(negedge clk);
        for (int i = 0; i < NI; i++) begin
            chk($sformatf("serialOutput[%0d]", i), serial_out[i], exp_tx(i));
            chk($sformatf("busy[%0d]", i),         busy[i],       m_len[i] != 0);
            chk($sformatf("dataReady[%0d]", i),    data_ready[i], !m_hold_full[i]);
            chk($sformatf("frameDone[%0d]", i),    frame_done[i], m_done[i]);
        end
        drive_and_step();
    endtask

    task automatic run(input int n);
        for (int k = 0; k < n; k++) cycle();
    endtask

    initial begin
        // Reset for three edges with a byte already offered, then 0xA5.
        for (int i = 0; i < NI; i++) push(i, 8'hA5, 0);
        rst_cnt = 3;
        drive_and_step();
        run(200);

        // All-zeros and all-ones bytes, parity edge cases.
        for (int i = 0; i < NI; i++) begin
            push(i, 8'h00, 0);
            push(i, 8'hFF, 5);
        end
        run(450);

        // Back-to-back: second byte offered about 20 cycles into the first frame.
        for (int i = 0; i < NI; i++) begin
            push(i, 8'h55, 0);
            push(i, 8'h0F, 19);
        end
        run(450);

        // Reset in the middle of a data bit, then a clean frame afterwards.
        for (int i = 0; i < NI; i++) push(i, 8'h3C, 0);
        run(70);
        rst_cnt = 1;
        for (int i = 0; i < NI; i++) push(i, 8'h96, 10);
        run(400);

        // STOP_BITS=2 instance gets 0x81 specifically.
        push(1, 8'h81, 0);
        run(120);

        // Random traffic with occasional resets.
        for (int k = 0; k < 4000; k++) begin
            for (int i = 0; i < NI; i++) begin
                if (q_size(i) < 2 && $urandom_range(0, 40) == 0)
                    push(i, 8'($urandom), int'($urandom_range(0, 60)));
            end
            if ($urandom_range(0, 1499) == 0) rst_cnt = 1 + int'($urandom_range(0, 2));
            cycle();
        end

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
